stl_rr_arbiter: RTL
===================

Name: stl_rr_arbiter

Overview:
Round-robin arbiter that shares one downstream stream channel (e.g. the single memory-bus port) between NR_REQ requesters (IFU, LSU, ...).
- Grants one requester per transaction, where a transaction is a burst of beats ending in last.
- Holds the grant until the final beat handshakes.
- Drives the select of the shared data/last mux and forwards valid/ready between the winner and the sink.

Parameters:
NR_REQ, 2, number of requesters (>=2)
DATA_LEN, 64, payload width per beat
IDX_LEN, $clog2(NR_REQ), width of requester index (derived, not overridable)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  synchronous active-low reset
i_req_valid  input  NR_REQ  per-requester beat valid
i_req_data  input  NR_REQ*DATA_LEN  per-requester payload, requester k at [k*DATA_LEN +: DATA_LEN]
i_req_last  input  NR_REQ  per-requester final-beat flag
o_req_ready  output  NR_REQ  per-requester ready
o_valid  output  1  downstream beat valid
o_data  output  DATA_LEN  downstream payload
o_last  output  1  downstream final-beat flag
i_ready  input  1  downstream ready
o_grant_idx  output  IDX_LEN  current owner index
o_busy  output  1  high while a transaction is owned

Behaviour:
- Interface: one clock i_clk; reset i_rst_n is synchronous, active-low.
- Reset (sampled low at posedge): state=IDLE, ptr=0, grant_idx=0. All outputs 0: o_valid, o_req_ready, o_data, o_last, o_busy, o_grant_idx.
- States:
  - IDLE: no owner.
  - BUSY: owner = grant_idx.
- IDLE -> BUSY, when any i_req_valid is high:
  - Winner = first set bit searching ptr, ptr+1, ..., NR_REQ-1, 0, ..., ptr-1 (wrap-around).
  - grant_idx <= winner. Registered; no beat transfers in this cycle.
  - o_req_ready = 0 for all requesters in IDLE.
- Arbitration latency: 1 cycle from first valid to first possible beat handshake.
- BUSY outputs (combinational pass-through):
  - o_valid = i_req_valid[grant_idx]; o_data/o_last = owner's data/last.
  - o_req_ready[grant_idx] = i_ready; all other ready bits = 0.
  - o_busy = 1.
- BUSY -> IDLE: on handshake (o_valid & i_ready) with o_last=1. At that edge, ptr <= grant_idx+1, wrapping to 0 at NR_REQ-1. grant_idx holds its value.
- Single-beat transaction: last=1 on first beat; takes 2 cycles (arbitrate + transfer). Back-to-back grants therefore have 1 idle cycle between transactions.
- Owner drops valid mid-burst: grant held, o_valid=0, no re-arbitration.
- Non-owner valids during BUSY: ignored, stalled (ready=0); they must keep their valid asserted.
- Owner's data/last must be stable while valid and not ready; the arbiter does not check this.
- Outside BUSY: o_data = 0 and o_last = 0 (no stale payload).
- Reset mid-burst: returns to IDLE, ptr=0 next cycle. The in-flight transaction is abandoned; requesters must also be reset.
- Fairness: every continuously requesting requester is granted within NR_REQ transactions.

Optional Feature:
STL_ARB_PERF_EN
- Defined: adds port o_grant_cnt (output, NR_REQ*32). One 32-bit counter per requester increments on each IDLE->BUSY grant to it; wraps at 2^32-1 -> 0; reset to 0.
- Not defined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package stl_arb_pkg: state enum arb_state_e {ARB_IDLE, ARB_BUSY}; localparam ARB_CNT_LEN=32.
- Sub-module stl_rr_picker: purely combinational.
  - Parameter: NR_REQ.
  - Inputs: req vector, ptr.
  - Outputs: found, idx.
  - Unit-testable in isolation.
- Top: FSM, ptr/grant registers, indexed data/last select, ready fan-out.

Test Plan:
1. Reset with all valids high, i_rst_n=0 for 3 cycles -> o_valid=0, o_req_ready=00, o_busy=0, o_grant_idx=0 throughout.
2. NR_REQ=2, req0 single beat (data=64'hA5, last=1), i_ready=1 -> o_busy at cycle+1, handshake at cycle+1 with o_data=64'hA5, IDLE at cycle+2, ptr=1.
3. Both valid continuously, 1-beat bursts, i_ready=1 -> grants alternate 0,1,0,1; each 2 cycles.
4. req1 4-beat burst, i_ready toggled 1,0,1,0,...; req0 valid throughout -> o_req_ready[0]=0 until req1's 4th beat handshakes; data order preserved; then req0 granted.
5. NR_REQ=4, ptr=3, valids=4'b0011 -> wrap-around grants idx 0; afterwards ptr=1.
6. Reset asserted on beat 2 of a 3-beat burst -> next cycle IDLE, ptr=0, o_valid=0. With STL_ARB_PERF_EN, o_grant_cnt=0.

Source files
------------

// File: rtl/stl_arb_pkg.sv
// Shared types and constants for the round-robin stream arbiter.
package stl_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_CNT_LEN = 32;

endpackage

// File: rtl/stl_rr_picker.sv
// Combinational round-robin search: first set request at or after ptr, wrapping.
module stl_rr_picker #(
  parameter  int NR_REQ  = 2,
  localparam int IDX_LEN = $clog2(NR_REQ)
) (
  input  logic [NR_REQ-1:0]  req_i,
  input  logic [IDX_LEN-1:0] ptr_i,
  output logic               found_o,
  output logic [IDX_LEN-1:0] idx_o
);

  logic [IDX_LEN-1:0] k;

  // Walk offsets from far to near so the closest hit to ptr is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    k       = '0;
    for (int off = NR_REQ-1; off >= 0; off--) begin
      k = IDX_LEN'((int'(ptr_i) + off) % NR_REQ);
      if (req_i[k]) begin
        found_o = 1'b1;
        idx_o   = k;
      end
    end
  end

endmodule

// File: rtl/stl_rr_arbiter.sv
// Round-robin arbiter granting one requester per burst on a shared stream channel.
// Optional per-requester grant counters behind STL_ARB_PERF_EN.
module stl_rr_arbiter
  import stl_arb_pkg::*;
#(
  parameter  int NR_REQ   = 2,
  parameter  int DATA_LEN = 64,
  localparam int IDX_LEN  = $clog2(NR_REQ)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NR_REQ-1:0]          i_req_valid,
  input  logic [NR_REQ*DATA_LEN-1:0] i_req_data,
  input  logic [NR_REQ-1:0]          i_req_last,
  output logic [NR_REQ-1:0]          o_req_ready,
  output logic                       o_valid,
  output logic [DATA_LEN-1:0]        o_data,
  output logic                       o_last,
  input  logic                       i_ready,
  output logic [IDX_LEN-1:0]         o_grant_idx,
`ifdef STL_ARB_PERF_EN
  output logic [NR_REQ*ARB_CNT_LEN-1:0] o_grant_cnt,
`endif
  output logic                       o_busy
);

  arb_state_e         state_q, state_d;
  logic [IDX_LEN-1:0] ptr_q, ptr_d;
  logic [IDX_LEN-1:0] grant_q, grant_d;
  logic               pick_found;
  logic [IDX_LEN-1:0] pick_idx;
  logic               busy;
  logic               last_hs;
  logic               grant_evt;

  stl_rr_picker #(.NR_REQ(NR_REQ)) u_pick (
    .req_i   (i_req_valid),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign busy      = (state_q == ARB_BUSY);
  assign grant_evt = (state_q == ARB_IDLE) && pick_found;
  assign last_hs   = o_valid && i_ready && i_req_last[grant_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_BUSY;
          grant_d = pick_idx;
        end
      end
      ARB_BUSY: begin
        // Pointer moves past the owner only once its burst has fully drained.
        if (last_hs) begin
          state_d = ARB_IDLE;
          ptr_d   = (grant_q == IDX_LEN'(NR_REQ-1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  // Owner pass-through; payload is forced to zero outside a transaction.
  assign o_valid     = busy && i_req_valid[grant_q];
  assign o_data      = busy ? i_req_data[int'(grant_q)*DATA_LEN +: DATA_LEN] : '0;
  assign o_last      = busy && i_req_last[grant_q];
  assign o_req_ready = busy ? (NR_REQ'(i_ready) << grant_q) : '0;
  assign o_grant_idx = grant_q;
  assign o_busy      = busy;

`ifdef STL_ARB_PERF_EN
  for (genvar g = 0; g < NR_REQ; g++) begin : g_cnt
    logic [ARB_CNT_LEN-1:0] cnt_q;
    always_ff @(posedge i_clk) begin
      if (!i_rst_n)
        cnt_q <= '0;
      else if (grant_evt && (pick_idx == IDX_LEN'(g)))
        cnt_q <= cnt_q + 1'b1;
    end
    assign o_grant_cnt[g*ARB_CNT_LEN +: ARB_CNT_LEN] = cnt_q;
  end
`else
  logic unused_grant_evt;
  assign unused_grant_evt = grant_evt;
`endif

endmodule
